// File: rtl/jtframe_sdram_pkg.sv
// Shared constants for the SDRAM bank-port helpers: FSM encodings and data width.
package jtframe_sdram_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam int         DW      = 32;
endpackage

// File: rtl/jtframe_bank_slot_arb_if.sv
// Bundle of the ROM-slot side and the bank-mux side of one shared SDRAM bank port.
interface jtframe_bank_slot_arb_if
  import jtframe_sdram_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) ();
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_rd;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                flush;
  logic [AW-1:0]       ba_addr;
  logic                ba_rd;
  logic                ba_ack;
  logic                ba_rdy;
  logic [DW-1:0]       ba_dout;

  modport slave (
    input  slot_addr, slot_rd, flush, ba_ack, ba_rdy, ba_dout,
    output slot_ok, slot_dout, ba_addr, ba_rd
  );

  modport master (
    output slot_addr, slot_rd, flush, ba_ack, ba_rdy, ba_dout,
    input  slot_ok, slot_dout, ba_addr, ba_rd
  );
endinterface

// File: rtl/jtframe_slot_cache.sv
// Single-entry read cache for one ROM slot; slot_ok is predicted from the
// post-update cache state so a fill is visible the cycle right after ba_rdy.
module jtframe_slot_cache
  import jtframe_sdram_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          fill_valid,
  output logic          hit,
  output logic          ok,
  output logic [DW-1:0] dout
);
  logic [AW-1:0] addr_c_r;
  logic [DW-1:0] data_c_r;
  logic          valid_c_r;
  logic          ok_r;
  logic [AW-1:0] addr_n_s;
  logic          valid_n_s;

  assign hit       = valid_c_r & rd & (addr == addr_c_r);
  assign addr_n_s  = fill ? fill_addr : addr_c_r;
  assign valid_n_s = flush ? 1'b0 : (fill ? fill_valid : valid_c_r);
  assign ok        = ok_r;
  assign dout      = data_c_r;

  // Cache entry and registered hit flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_c_r  <= '0;
      data_c_r  <= '0;
      valid_c_r <= 1'b0;
      ok_r      <= 1'b0;
    end else begin
      addr_c_r  <= addr_n_s;
      valid_c_r <= valid_n_s;
      if (fill) begin
        data_c_r <= fill_data;
      end
      ok_r <= rd & valid_n_s & (addr == addr_n_s);
    end
  end
endmodule

// File: rtl/jtframe_bank_slot_arb.sv
// Round-robin sharing of one read-only SDRAM bank port among SLOTS ROM clients,
// one outstanding request at a time, with a one-word cache per slot.
module jtframe_bank_slot_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  jtframe_bank_slot_arb_if.slave   bus
);
  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [1:0]          state_r;
  logic [PW-1:0]       rr_ptr_r;
  logic [PW-1:0]       sel_r;
  logic                ba_rd_r;
  logic [AW-1:0]       ba_addr_r;
  logic                flush_pend_r;
  logic [SLOTS-1:0]    hit_s;
  logic [SLOTS-1:0]    need_s;
  logic [SLOTS-1:0]    ok_s;
  logic [SLOTS*DW-1:0] dout_s;
  logic                fill_s;
  logic                fill_valid_s;
  logic [PW-1:0]       pick_s;
  logic                any_s;
  logic [PW:0]         idx_s;

  // A flush landing on the ready cycle must also spoil the in-flight fill
  assign fill_s        = (state_r == ST_WAIT) & bus.ba_rdy;
  assign fill_valid_s  = ~(flush_pend_r | bus.flush);
  assign need_s        = bus.slot_rd & ~hit_s;
  assign bus.slot_ok   = ok_s;
  assign bus.slot_dout = dout_s;
  assign bus.ba_rd     = ba_rd_r;
  assign bus.ba_addr   = ba_addr_r;

  generate
    for (genvar i = 0; i < SLOTS; i++) begin : gen_slot
      jtframe_slot_cache #(.AW(AW)) u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (bus.slot_addr[i*AW +: AW]),
        .rd         (bus.slot_rd[i]),
        .flush      (bus.flush),
        .fill       (fill_s && (sel_r == PW'(i))),
        .fill_addr  (ba_addr_r),
        .fill_data  (bus.ba_dout),
        .fill_valid (fill_valid_s),
        .hit        (hit_s[i]),
        .ok         (ok_s[i]),
        .dout       (dout_s[i*DW +: DW])
      );
    end
  endgenerate

  // First needy slot scanning upward from rr_ptr with wrap-around
  always_comb begin
    pick_s = '0;
    any_s  = 1'b0;
    idx_s  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (PW+1)'(k);
      if (idx_s >= (PW+1)'(SLOTS)) begin
        idx_s = idx_s - (PW+1)'(SLOTS);
      end else begin
        idx_s = idx_s;
      end
      if (!any_s && need_s[idx_s[PW-1:0]]) begin
        any_s  = 1'b1;
        pick_s = idx_s[PW-1:0];
      end else begin
        any_s  = any_s;
      end
    end
  end

  // Request FSM: IDLE picks, REQ waits for ack, WAIT waits for data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      sel_r        <= '0;
      ba_rd_r      <= 1'b0;
      ba_addr_r    <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          flush_pend_r <= 1'b0;
          if (any_s) begin
            sel_r     <= pick_s;
            ba_addr_r <= bus.slot_addr[int'(pick_s)*AW +: AW];
            ba_rd_r   <= 1'b1;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.flush) begin
            flush_pend_r <= 1'b1;
          end
          if (bus.ba_ack) begin
            ba_rd_r <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.ba_rdy) begin
            rr_ptr_r     <= (sel_r == PW'(SLOTS-1)) ? '0 : sel_r + PW'(1);
            flush_pend_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (bus.flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          ba_rd_r      <= 1'b0;
          flush_pend_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
